adder_arbiter: RTL

- Round-robin arbiter and sequencer that shares one external 16-bit ripple adder (Adder_16 instance in the parent) between NREQ requesters.
- Each requester presents operands with a request. The block grants one requester per cycle, drives the shared adder from registered operand outputs, and returns sum/carry tagged to the winning requester.
- Fully pipelined: one new addition can be accepted every cycle.

---
 rtl/adder_arbiter_if.sv | 36 +++
 rtl/adder_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if
// Requester-side bundle for adder_arbiter: requests with their operand
// slices, the combinational grant vector, and the tagged result return.
//   req       : per-requester request, bit i qualifies slice i
//   a_in/b_in : packed operands, requester i uses [i*WIDTH +: WIDTH]
//   cin_in    : per-requester carry-in
//   gnt       : one-hot grant, combinational
//   rsp_valid : one-hot, one-cycle result strobe
//   rsp_sum   : result sum, meaningful only while rsp_valid is non-zero
//   rsp_cout  : result carry-out
//   busy      : an accepted operation has not yet returned its result
// master = requester side (the parent), slave = the arbiter.
interface adder_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       cin_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  busy;

   modport master (
      output req, a_in, b_in, cin_in,
      input  gnt, rsp_valid, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req, a_in, b_in, cin_in,
      output gnt, rsp_valid, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter and two-stage sequencer that shares one external
// WIDTH-bit adder between NREQ requesters. One requester is granted per
// cycle; its operands are registered onto add_a/add_b/add_cin, and the
// adder's sum/carry are registered one edge later and returned with a
// one-hot rsp_valid tag. A grant in cycle T returns in cycle T+2.
//   clk      : rising-edge clock
//   rst      : asynchronous, active-low reset
//   bus      : requester bundle (adder_arbiter_if.slave)
//   add_a    : registered operand A to the shared adder
//   add_b    : registered operand B to the shared adder
//   add_cin  : registered carry-in to the shared adder
//   add_sum  : shared adder sum, combinational from add_a/add_b/add_cin
//   add_cout : shared adder carry-out
module adder_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int IDXW  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_arbiter_if.slave        bus,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_cin,
   input  logic [WIDTH-1:0]      add_sum,
   input  logic                  add_cout
);

   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] win_idx;
   logic [IDXW-1:0] cand_idx;
   logic            win;
   logic [NREQ-1:0] gnt_c;
   int              cand;

   logic            s1_valid;
   logic [IDXW-1:0] s1_idx;

   logic [NREQ-1:0] rsp_valid_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic            rsp_cout_q;

   // Round-robin search: walk the request vector starting at ptr, wrapping
   // modulo NREQ, and take the first set bit. The grant is forced low while
   // reset is held so nothing appears taken during reset.
   always_comb begin
      win      = 1'b0;
      win_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      gnt_c    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDXW'(cand);
         if (!win && bus.req[cand_idx]) begin
            win     = 1'b1;
            win_idx = cand_idx;
         end
      end
      if (win && rst) begin
         gnt_c[win_idx] = 1'b1;
      end
   end

   // Stage 1: on a grant, move the priority pointer just past the winner and
   // capture the winner's operand slices onto the shared adder inputs. With
   // no grant the adder inputs hold so the adder does not toggle needlessly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         add_a    <= '0;
         add_b    <= '0;
         add_cin  <= 1'b0;
      end else begin
         if (win) begin
            ptr      <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            s1_valid <= 1'b1;
            s1_idx   <= win_idx;
            add_a    <= bus.a_in[win_idx*WIDTH +: WIDTH];
            add_b    <= bus.b_in[win_idx*WIDTH +: WIDTH];
            add_cin  <= bus.cin_in[win_idx];
         end else begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: the adder has had a full cycle to settle on the stage-1
   // operands, so capture its result and tag it with the requester that was
   // granted. The result registers hold between operations.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         if (s1_valid) begin
            rsp_valid_q <= NREQ'(1) << s1_idx;
            rsp_sum_q   <= add_sum;
            rsp_cout_q  <= add_cout;
         end else begin
            rsp_valid_q <= '0;
         end
      end
   end

   // busy is built only from pipeline registers, so it has no path from req.
   assign bus.gnt       = gnt_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = s1_valid | (|rsp_valid_q);

endmodule
